// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: word-addressed data RAM with a
// configurable wait-state count, branch resolution and the MEM/WB register.
module mem_access_stage #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inAdder,
    input  logic        inZf,
    input  logic [31:0] inOutAlu,
    input  logic [31:0] inRD2,
    input  logic [4:0]  inMux5b,
    input  logic        inMemRead,
    input  logic        inMemWrite,
    input  logic        inBranch,
    input  logic        inRegWrite,
    input  logic        inMemToReg,
    output logic        outPcSrc,
    output logic [31:0] outBranchTarget,
    output logic        stall,
    output logic [31:0] outReadData,
    output logic [31:0] outOutAlu,
    output logic [4:0]  outMux5b,
    output logic        outRegWrite,
    output logic        outMemToReg,
    output logic        outAlignErr
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic {
        IDLE,
        WAIT
    } stateT;

    stateT      state;
    stateT      stateNext;
    logic [3:0] cnt;
    logic [3:0] cntNext;

    logic             memOp;
    logic             isLoad;
    logic             isStore;
    logic             misaligned;
    logic [IDX_W-1:0] index;
    logic             unusedAddrBits;

    logic [31:0] mem [DEPTH];

    // A simultaneous read and write request is a store.
    assign memOp          = inMemRead | inMemWrite;
    assign isStore        = inMemWrite;
    assign isLoad         = inMemRead & ~inMemWrite;
    assign misaligned     = memOp & (inOutAlu[1:0] != 2'b00);
    assign index          = inOutAlu[IDX_W+1:2];
    assign unusedAddrBits = ^inOutAlu[31:IDX_W+2];

    // Branch resolution is never held back by a memory stall.
    assign outPcSrc        = inBranch & inZf;
    assign outBranchTarget = inAdder;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        stateNext = state;
        cntNext   = cnt;
        stall     = 1'b0;
        unique case (state)
            IDLE: begin
                if (memOp && (LATENCY > 0)) begin
                    stall     = 1'b1;
                    stateNext = WAIT;
                    cntNext   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    stall   = 1'b1;
                    cntNext = cnt - 4'd1;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            outReadData <= 32'd0;
            outOutAlu   <= 32'd0;
            outMux5b    <= 5'd0;
            outRegWrite <= 1'b0;
            outMemToReg <= 1'b0;
            outAlignErr <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (stall) begin
                // Bubble into MEM/WB while the access is still in flight.
                outRegWrite <= 1'b0;
                outMemToReg <= 1'b0;
                outAlignErr <= 1'b0;
            end else begin
                outReadData <= (isLoad && !misaligned) ? mem[index] : 32'd0;
                outOutAlu   <= inOutAlu;
                outMux5b    <= inMux5b;
                outRegWrite <= inRegWrite & ~misaligned;
                outMemToReg <= inMemToReg;
                outAlignErr <= misaligned;
            end
        end
    end

    // NOTE: the RAM has no reset; its contents must survive rst and stay mappable to block RAM.
    always_ff @(posedge clk) begin
        if (!rst && !stall && isStore && !misaligned) begin
            mem[index] <= inRD2;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: three instances (LATENCY 0, 2, 3) checked every
// cycle against a cycle-counting reference model, plus directed sequences.
module tb_mem_access_stage;

    typedef struct packed {
        logic        rst;
        logic [31:0] adder;
        logic        zf;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  mux;
        logic        memRead;
        logic        memWrite;
        logic        branch;
        logic        regWrite;
        logic        memToReg;
    } inT;

    typedef struct packed {
        logic [31:0] readData;
        logic [31:0] alu;
        logic [4:0]  mux;
        logic        regWrite;
        logic        memToReg;
        logic        alignErr;
    } regT;

    typedef struct {
        inT   in;
        logic stall;
        logic pcSrc;
        regT  wb;
    } vecT;

    localparam int NDUT = 3;
    localparam int LATS [NDUT] = '{0, 2, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    inT          din    [NDUT];
    logic        stallW [NDUT];
    logic        pcSrcW [NDUT];
    logic [31:0] tgtW   [NDUT];
    regT         regW   [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        logic        pcSrc, stl, rw, m2r, ae;
        logic [31:0] tgt, rdData, alu;
        logic [4:0]  mux;
        mem_access_stage #(.DEPTH(256), .LATENCY(g == 0 ? 0 : g + 1)) dut (
            .clk            (clk),
            .rst            (din[g].rst),
            .inAdder        (din[g].adder),
            .inZf           (din[g].zf),
            .inOutAlu       (din[g].alu),
            .inRD2          (din[g].rd2),
            .inMux5b        (din[g].mux),
            .inMemRead      (din[g].memRead),
            .inMemWrite     (din[g].memWrite),
            .inBranch       (din[g].branch),
            .inRegWrite     (din[g].regWrite),
            .inMemToReg     (din[g].memToReg),
            .outPcSrc       (pcSrc),
            .outBranchTarget(tgt),
            .stall          (stl),
            .outReadData    (rdData),
            .outOutAlu      (alu),
            .outMux5b       (mux),
            .outRegWrite    (rw),
            .outMemToReg    (m2r),
            .outAlignErr    (ae)
        );
        assign stallW[g] = stl;
        assign pcSrcW[g] = pcSrc;
        assign tgtW[g]   = tgt;
        assign regW[g]   = {rdData, alu, mux, rw, m2r, ae};
    end

    // Reference model: memory image, cycles an op has been presented, expected MEM/WB.
    logic [31:0] refMem [NDUT][256];
    int          age    [NDUT];
    regT         expR   [NDUT];
    bit          done   [NDUT];
    logic        lastStall [NDUT];
    logic        lastPcSrc [NDUT];
    logic [31:0] lastTgt   [NDUT];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int d, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
        end
    endtask

    function automatic inT idleIn();
        return '0;
    endfunction

    function automatic inT mkIn(logic rd, logic wr, logic [31:0] alu, logic [31:0] rd2, logic [4:0] mux,
                                logic rw, logic m2r, logic br, logic zf, logic [31:0] adder);
        inT v = '0;
        v.memRead  = rd;
        v.memWrite = wr;
        v.alu      = alu;
        v.rd2      = rd2;
        v.mux      = mux;
        v.regWrite = rw;
        v.memToReg = m2r;
        v.branch   = br;
        v.zf       = zf;
        v.adder    = adder;
        return v;
    endfunction

    function automatic regT mkReg(logic [31:0] rdata, logic [31:0] alu, logic [4:0] mux,
                                  logic rw, logic m2r, logic ae);
        regT r;
        r.readData = rdata;
        r.alu      = alu;
        r.mux      = mux;
        r.regWrite = rw;
        r.memToReg = m2r;
        r.alignErr = ae;
        return r;
    endfunction

    // One clock for all instances: combinational checks at negedge, MEM/WB checks after posedge.
    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            inT   v   = din[d];
            bit   op  = v.memRead | v.memWrite;
            bit   es  = op && (age[d] < LATS[d]);
            bit   mis = op && (v.alu[1:0] != 2'b00);
            logic [7:0] idx = v.alu[9:2];
            lastStall[d] = stallW[d];
            lastPcSrc[d] = pcSrcW[d];
            lastTgt[d]   = tgtW[d];
            check("stall", d, 72'(stallW[d]), 72'(es));
            check("pc_src", d, 72'(pcSrcW[d]), 72'(v.branch & v.zf));
            check("branch_target", d, 72'(tgtW[d]), 72'(v.adder));
            done[d] = 1'b0;
            if (v.rst) begin
                expR[d] = '0;
                age[d]  = 0;
            end else if (es) begin
                age[d]++;
                expR[d].regWrite = 1'b0;
                expR[d].memToReg = 1'b0;
                expR[d].alignErr = 1'b0;
            end else begin
                expR[d].readData = (v.memRead && !v.memWrite && !mis) ? refMem[d][idx] : 32'd0;
                if (v.memWrite && !mis) refMem[d][idx] = v.rd2;
                expR[d].alu      = v.alu;
                expR[d].mux      = v.mux;
                expR[d].regWrite = v.regWrite && !mis;
                expR[d].memToReg = v.memToReg;
                expR[d].alignErr = mis;
                age[d]  = 0;
                done[d] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) check("mem_wb", d, 72'(regW[d]), 72'(expR[d]));
    endtask

    // Present an op until the model says it completed; returns stall cycles the DUT showed.
    task automatic doOp(input int d, input inT v, output int stalls);
        stalls = 0;
        din[d] = v;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (lastStall[d] === 1'b1) stalls++;
            if (done[d]) break;
        end
        din[d] = idleIn();
    endtask

    vecT vec [12];

    initial begin
        int    stalls;
        inT    v;
        logic [31:0] old;
        logic [31:0] a;

        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          stalls;
        int          d;
        int          kind;
        int          k;
        inT          v;
        logic [31:0] old;
        logic [31:0] a;

        for (int i = 0; i < NDUT; i++) begin
            din[i]     = idleIn();
            din[i].rst = 1'b1;
            age[i]     = 0;
            expR[i]    = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check("reset_regs", i, 72'(regW[i]), 72'(0));
            check("reset_stall", i, 72'(stallW[i]), 72'(0));
        end
        for (int i = 0; i < NDUT; i++) din[i] = idleIn();

        // Directed single-cycle vectors on the LATENCY=0 instance.
        vec[0]  = '{mkIn(0, 0, 32'h1234, 32'h0, 5'd7, 1, 0, 0, 0, 32'h0), 0, 0, mkReg(32'h0, 32'h1234, 5'd7, 1, 0, 0)};
        vec[1]  = '{mkIn(0, 1, 32'h10, 32'hCAFEF00D, 5'd3, 0, 0, 0, 0, 32'h0), 0, 0, mkReg(32'h0, 32'h10, 5'd3, 0, 0, 0)};
        vec[2]  = '{mkIn(1, 0, 32'h10, 32'h0, 5'd5, 1, 1, 0, 0, 32'h0), 0, 0, mkReg(32'hCAFEF00D, 32'h10, 5'd5, 1, 1, 0)};
        vec[3]  = '{mkIn(0, 1, 32'h13, 32'hAAAA5555, 5'd2, 1, 0, 0, 0, 32'h0), 0, 0, mkReg(32'h0, 32'h13, 5'd2, 0, 0, 1)};
        vec[4]  = '{mkIn(1, 0, 32'h10, 32'h0, 5'd6, 1, 1, 0, 0, 32'h0), 0, 0, mkReg(32'hCAFEF00D, 32'h10, 5'd6, 1, 1, 0)};
        vec[5]  = '{mkIn(0, 1, 32'h400, 32'h77, 5'd0, 0, 0, 0, 0, 32'h0), 0, 0, mkReg(32'h0, 32'h400, 5'd0, 0, 0, 0)};
        vec[6]  = '{mkIn(1, 0, 32'h0, 32'h0, 5'd9, 1, 1, 0, 0, 32'h0), 0, 0, mkReg(32'h77, 32'h0, 5'd9, 1, 1, 0)};
        vec[7]  = '{mkIn(1, 1, 32'h8, 32'h1, 5'd4, 1, 0, 0, 0, 32'h0), 0, 0, mkReg(32'h0, 32'h8, 5'd4, 1, 0, 0)};
        vec[8]  = '{mkIn(1, 0, 32'h8, 32'h0, 5'd4, 1, 1, 0, 0, 32'h0), 0, 0, mkReg(32'h1, 32'h8, 5'd4, 1, 1, 0)};
        vec[9]  = '{mkIn(0, 0, 32'h55, 32'h0, 5'd1, 0, 0, 1, 1, 32'h40), 0, 1, mkReg(32'h0, 32'h55, 5'd1, 0, 0, 0)};
        vec[10] = '{mkIn(0, 0, 32'h56, 32'h0, 5'd1, 0, 0, 1, 0, 32'h40), 0, 0, mkReg(32'h0, 32'h56, 5'd1, 0, 0, 0)};
        vec[11] = '{mkIn(1, 0, 32'h11, 32'h0, 5'd3, 1, 1, 0, 0, 32'h0), 0, 0, mkReg(32'h0, 32'h11, 5'd3, 0, 1, 1)};
        for (int i = 0; i < 12; i++) begin
            din[0] = vec[i].in;
            tick();
            check("tbl_stall", i, 72'(lastStall[0]), 72'(vec[i].stall));
            check("tbl_pc_src", i, 72'(lastPcSrc[0]), 72'(vec[i].pcSrc));
            check("tbl_mem_wb", i, 72'(regW[0]), 72'(vec[i].wb));
        end
        din[0] = idleIn();

        // Give every instance a known memory image.
        for (int i = 0; i < NDUT; i++)
            for (int w = 0; w < 256; w++)
                doOp(i, mkIn(0, 1, 32'(w * 4), $urandom, 5'd0, 0, 0, 0, 0, 32'h0), stalls);

        // LATENCY=2: store then load with two stall cycles each.
        doOp(1, mkIn(0, 1, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0, 0, 0, 32'h0), stalls);
        check("l2_store_stalls", 1, 72'(stalls), 72'(2));
        din[1] = mkIn(1, 0, 32'h10, 32'h0, 5'd5, 1, 1, 0, 0, 32'h0);
        tick();
        check("l2_bubble_rw", 1, 72'(regW[1].regWrite), 72'(0));
        doOp(1, din[1], stalls);
        check("l2_load_stalls", 1, 72'(stalls), 72'(1));
        check("l2_load_data", 1, 72'(regW[1].readData), 72'(32'hDEADBEEF));
        check("l2_load_mux", 1, 72'(regW[1].mux), 72'(5));
        check("l2_load_rw", 1, 72'(regW[1].regWrite), 72'(1));

        // Branch resolution is combinational.
        din[1] = mkIn(0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 1, 1, 32'h40);
        tick();
        check("br_taken", 1, 72'(lastPcSrc[1]), 72'(1));
        check("br_target", 1, 72'(lastTgt[1]), 72'(32'h40));
        din[1].zf = 1'b0;
        tick();
        check("br_not_taken", 1, 72'(lastPcSrc[1]), 72'(0));
        din[1] = idleIn();

        // Wrap-around on LATENCY=2.
        doOp(1, mkIn(0, 1, 32'h400, 32'h77, 5'd0, 0, 0, 0, 0, 32'h0), stalls);
        doOp(1, mkIn(1, 0, 32'h0, 32'h0, 5'd1, 1, 1, 0, 0, 32'h0), stalls);
        check("wrap_load", 1, 72'(regW[1].readData), 72'(32'h77));

        // LATENCY=3: misaligned store is suppressed and flagged.
        old = refMem[2][4];
        doOp(2, mkIn(0, 1, 32'h13, 32'hAAAA5555, 5'd0, 1, 0, 0, 0, 32'h0), stalls);
        check("mis_stalls", 2, 72'(stalls), 72'(3));
        check("mis_align_err", 2, 72'(regW[2].alignErr), 72'(1));
        check("mis_rw", 2, 72'(regW[2].regWrite), 72'(0));
        doOp(2, mkIn(1, 0, 32'h10, 32'h0, 5'd2, 1, 1, 0, 0, 32'h0), stalls);
        check("mis_load_old", 2, 72'(regW[2].readData), 72'(old));
        check("mis_err_clear", 2, 72'(regW[2].alignErr), 72'(0));

        // LATENCY=3: reset during the second stall cycle abandons the store.
        old = refMem[2][8];
        din[2] = mkIn(0, 1, 32'h20, 32'h11, 5'd3, 1, 1, 0, 0, 32'h0);
        tick();
        din[2].rst = 1'b1;
        tick();
        check("rst_stall_seen", 2, 72'(lastStall[2]), 72'(1));
        check("rst_regs", 2, 72'(regW[2]), 72'(0));
        din[2] = idleIn();
        tick();
        check("rst_idle", 2, 72'(lastStall[2]), 72'(0));
        doOp(2, mkIn(1, 0, 32'h20, 32'h0, 5'd3, 1, 1, 0, 0, 32'h0), stalls);
        check("rst_load_old", 2, 72'(regW[2].readData), 72'(old));

        // Randomized traffic, occasionally interrupted by reset.
        for (int n = 0; n < 400; n++) begin
            d    = $urandom_range(0, NDUT - 1);
            kind = $urandom_range(0, 9);
            a    = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 1) != 0) a[31:10] = '0;
            v          = idleIn();
            v.alu      = a;
            v.rd2      = $urandom;
            v.mux      = 5'($urandom);
            v.adder    = $urandom;
            v.zf       = 1'($urandom);
            v.branch   = 1'($urandom);
            v.regWrite = 1'($urandom);
            v.memToReg = 1'($urandom);
            v.memRead  = (kind < 4) || (kind == 8);
            v.memWrite = ((kind >= 4) && (kind < 7)) || (kind == 8);
            if ((v.memRead || v.memWrite) && $urandom_range(0, 19) == 0) begin
                k      = $urandom_range(0, LATS[d]);
                din[d] = v;
                repeat (k) tick();
                din[d].rst = 1'b1;
                tick();
                din[d] = idleIn();
            end else begin
                doOp(d, v, stalls);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM buffer.
- Consumes the EX/MEM buffer outputs: branch-target adder result, zero flag, ALU result, RD2 store data and destination register.
- Performs the data-memory access on a word-addressed internal RAM with a configurable wait-state count, stalling upstream while busy.
- Resolves the branch and registers the result into MEM/WB fields.

Parameters:
DEPTH, 256, data memory size in 32-bit words; power of 2; index = inOutAlu[log2(DEPTH)+1:2]
LATENCY, 2, wait states per load/store (0..15); 0 = single-cycle access

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
inAdder  input  32  branch target from EX/MEM
inZf  input  1  ALU zero flag from EX/MEM
inOutAlu  input  32  ALU result = byte address for loads/stores
inRD2  input  32  store data
inMux5b  input  5  destination register
inMemRead  input  1  load request
inMemWrite  input  1  store request
inBranch  input  1  branch instruction
inRegWrite  input  1  writeback enable
inMemToReg  input  1  writeback select
outPcSrc  output  1  combinational: inBranch & inZf
outBranchTarget  output  32  combinational: inAdder
stall  output  1  combinational: upstream must hold EX/MEM contents
outReadData  output  32  registered load data
outOutAlu  output  32  registered ALU result
outMux5b  output  5  registered destination register
outRegWrite  output  1  registered writeback enable
outMemToReg  output  1  registered writeback select
outAlignErr  output  1  registered misaligned-access flag

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE; cnt=0.
  - All registered outputs go to 0.
  - Any pending access is abandoned; a pending store is never written.
  - Memory contents are not cleared.
- Memory op: op = inMemRead | inMemWrite.
  - Both asserted: treated as a store; outReadData=0.
- FSM states IDLE, WAIT; 4-bit down-counter cnt.
  - IDLE, op=1, LATENCY>0: stall=1; next state WAIT; cnt<=LATENCY-1.
  - IDLE, op=0, or LATENCY=0: stall=0; the access completes in this cycle.
  - WAIT, cnt!=0: stall=1; cnt<=cnt-1.
  - WAIT, cnt==0: stall=0; the access completes; next state IDLE.
- stall is high for exactly LATENCY consecutive cycles per memory op. The op completes on the (LATENCY+1)-th cycle it is presented.
- Completion cycle (stall=0), at posedge:
  - Store: mem[index] <= inRD2.
  - Load: outReadData <= mem[index], pre-write contents.
  - Non-op: outReadData <= 0.
  - outOutAlu, outMux5b, outRegWrite and outMemToReg load from inputs.
- Stalled cycle (stall=1): the MEM/WB register loads a bubble. outRegWrite=0, outMemToReg=0, outAlignErr=0; other outputs hold.
- Misalignment: op with inOutAlu[1:0]!=0.
  - The access is suppressed: no write, outReadData=0.
  - outAlignErr=1 for the completion cycle.
  - outRegWrite is forced to 0.
  - Wait states still apply.
- Addresses beyond DEPTH wrap modulo DEPTH; upper address bits are ignored.
- Inputs are assumed stable while stall=1. Changes during WAIT are sampled only at completion.
- outPcSrc and outBranchTarget are combinational and are not gated by stall.
- Back-to-back ops: IDLE re-enters WAIT immediately on the cycle after completion, with no idle bubble beyond the stall cycles.

Test Plan:
- LATENCY=2: store inOutAlu=0x10, inRD2=0xDEADBEEF. Then load 0x10, inMux5b=5, inRegWrite=1 -> stall high 2 cycles for each op. Load completion gives outReadData=0xDEADBEEF, outMux5b=5, outRegWrite=1; bubbles (outRegWrite=0) on the stalled cycles.
- LATENCY=0: ALU op inOutAlu=0x1234, inRegWrite=1, no mem op -> stall never asserts. Next cycle outOutAlu=0x1234, outReadData=0.
- Misaligned store at 0x13 with 0xAAAA5555, then aligned load at 0x10 -> outAlignErr=1 on store completion; the load returns the prior contents, not 0xAAAA5555.
- inBranch=1, inZf=1, inAdder=0x40 -> outPcSrc=1 and outBranchTarget=0x40 in the same cycle. With inZf=0 -> outPcSrc=0.
- LATENCY=3: start store 0x20=0x11, assert rst during the second stall cycle, then load 0x20 -> state IDLE, stall drops, all outputs 0. The load returns the old content, not 0x11.
- DEPTH=256: store 0x400 = 0x77, then load 0x0 -> returns 0x77 (wrap-around).
